// File: rtl/ex_div_pkg.sv
// Shared types and constants for the RV32M divide/remainder sequencer.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package ex_div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  localparam int XLEN = 32;

  // Quotient returned for a zero divisor.
  localparam logic [XLEN-1:0] DIV_ZERO_QUO     = '1;
  // Most negative dividend; with divisor -1 the signed quotient overflows.
  localparam logic [XLEN-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/ex_div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, trial-subtract divisor.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module ex_div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] next_rem,
  output logic [DATA_WIDTH-1:0] next_quo
);

  // rem < divisor always holds on entry, so the shifted partial remainder
  // needs one extra bit; the trial result's top bit is the borrow.
  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;
  logic                borrow;

  // Trial subtraction; keep it only when it does not borrow.
  always_comb begin
    shifted  = {rem, quo[DATA_WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    borrow   = trial[DATA_WIDTH];
    next_rem = borrow ? shifted[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
    next_quo = {quo[DATA_WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/ex_div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU sequencer, restoring radix-2, one quotient bit per cycle.
// Latency: valid_o 33 cycles after start (1 cycle for div-by-zero/overflow, and early-out if DIV_EARLY_OUT_EN).
// Backpressure: busy_o holds the pipeline while not IDLE; start_i ignored outside IDLE; flush_i aborts.
module ex_div_ctrl
  import ex_div_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic [4:0]            reg_waddr_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  reg_wen_o,
  output logic [4:0]            reg_waddr_o
);

  div_state_e            state_q, state_d;
  div_op_e               op_q;
  logic [DATA_WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic                  quo_neg_q, rem_neg_q, bypass_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [4:0]            waddr_q, waddr_out_q;
  logic [DATA_WIDTH-1:0] result_q;

  div_op_e               op_in;
  logic                  in_signed, dvd_neg, dvs_neg;
  logic [DATA_WIDTH-1:0] dvd_abs, dvs_abs;
  logic                  div_zero, ovf, early, quick, accept, last_step;
  logic [DATA_WIDTH-1:0] step_rem, step_quo;
  logic [DATA_WIDTH-1:0] quo_fin, rem_fin, final_res;

  // Decode the incoming request: magnitudes and the cases that skip iteration.
  always_comb begin
    op_in     = div_op_e'(op_i);
    in_signed = op_is_signed(op_in);
    dvd_neg   = in_signed & dividend_i[DATA_WIDTH-1];
    dvs_neg   = in_signed & divisor_i[DATA_WIDTH-1];
    dvd_abs   = dvd_neg ? -dividend_i : dividend_i;
    dvs_abs   = dvs_neg ? -divisor_i : divisor_i;
    div_zero  = (divisor_i == '0);
    ovf       = in_signed && (dividend_i == DATA_WIDTH'(DIV_OVF_DIVIDEND)) && (divisor_i == '1);
`ifdef DIV_EARLY_OUT_EN
    early     = !div_zero && (dvd_abs < dvs_abs);
`else
    early     = 1'b0;
`endif
    quick     = div_zero | ovf | early;
    accept    = (state_q == IDLE) && start_i && !flush_i;
    last_step = (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));
  end

  ex_div_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .next_rem (step_rem),
    .next_quo (step_quo)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs; flush overrides everything.
  always_comb begin
    state_d = state_q;
    busy_o  = (state_q != IDLE);
    valid_o = 1'b0;
    case (state_q)
      IDLE: if (start_i) state_d = quick ? DONE : CALC;
      CALC: if (last_step) state_d = DONE;
      DONE: begin
        valid_o = ~flush_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  assign reg_wen_o = valid_o;

  // Apply result signs; pre-computed special results are already final.
  always_comb begin
    quo_fin = quo_q;
    rem_fin = rem_q;
    if (!bypass_q) begin
      if (quo_neg_q) quo_fin = -quo_q;
      if (rem_neg_q) rem_fin = -rem_q;
    end
    final_res = op_is_rem(op_q) ? rem_fin : quo_fin;
  end

  // Outputs show the live result in DONE and hold it afterwards.
  assign result_o    = valid_o ? final_res : result_q;
  assign reg_waddr_o = valid_o ? waddr_q : waddr_out_q;

  // Operand capture, iteration and result hold registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q        <= DIV;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      bypass_q    <= 1'b0;
      cnt_q       <= '0;
      waddr_q     <= '0;
      waddr_out_q <= '0;
      result_q    <= '0;
    end else begin
      if (accept) begin
        op_q      <= op_in;
        waddr_q   <= reg_waddr_i;
        cnt_q     <= '0;
        dvs_q     <= dvs_abs;
        quo_neg_q <= dvd_neg ^ dvs_neg;
        rem_neg_q <= dvd_neg;
        bypass_q  <= quick;
        if (div_zero) begin
          quo_q <= DATA_WIDTH'(DIV_ZERO_QUO);
          rem_q <= dividend_i;
        end else if (ovf) begin
          quo_q <= DATA_WIDTH'(DIV_OVF_DIVIDEND);
          rem_q <= '0;
        end else if (early) begin
          quo_q <= '0;
          rem_q <= dividend_i;
        end else begin
          quo_q <= dvd_abs;
          rem_q <= '0;
        end
      end else if (state_q == CALC) begin
        rem_q <= step_rem;
        quo_q <= step_quo;
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      if (valid_o) begin
        result_q    <= final_res;
        waddr_out_q <= waddr_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Self-checking bench for ex_div_ctrl: directed vectors, corner sequences, random ops vs model.
// Latency: checks cycle-exact valid_o timing relative to the start cycle.
// Backpressure: exercises flush, reset and start while busy.
module tb_ex_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] dvd, dvs;
  logic [4:0]  waddr_in;
  logic        busy, valid, wen;
  logic [31:0] result;
  logic [4:0]  waddr_out;

  int errors = 0;
  int checks = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  ex_div_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .op_i        (op),
    .dividend_i  (dvd),
    .divisor_i   (dvs),
    .reg_waddr_i (waddr_in),
    .flush_i     (flush),
    .busy_o      (busy),
    .valid_o     (valid),
    .result_o    (result),
    .reg_wen_o   (wen),
    .reg_waddr_o (waddr_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Architectural RV32M results.
  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return (o[1] == 1'b0) ? 32'hFFFF_FFFF : a;
    if (o[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (o == 2'b00) ? 32'h8000_0000 : 32'd0;
    case (o)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (o[0] == 1'b0 && a[31]) ? 32'(-a) : a;
    mb = (o[0] == 1'b0 && b[31]) ? 32'(-b) : b;
    if (b == 32'd0) return 1;
    if (o[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`else
    if (ma < mb) return 33;
`endif
    return 33;
  endfunction

  // Called just after the posedge that sampled start; returns just after the
  // negedge of the IDLE cycle following DONE.
  task automatic wait_result(input string name, input logic [31:0] exp_res,
                             input int exp_lat, input logic [4:0] exp_wa);
    int lat;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        chk({name, "_busy"}, 32'(busy), 32'd1);
      end
      if (valid) begin
        lat = k;
        chk({name, "_lat"}, 32'(k), 32'(exp_lat));
        chk({name, "_res"}, result, exp_res);
        chk({name, "_waddr"}, 32'(waddr_out), 32'(exp_wa));
        chk({name, "_wen"}, 32'(wen), 32'd1);
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no valid_o within 40 cycles, expected at %0d", name, exp_lat);
    end
    @(negedge clk);
    chk({name, "_pulse"}, 32'(valid), 32'd0);
    chk({name, "_hold"}, result, exp_res);
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wa;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int nval, lat;
    logic [31:0] res;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [4:0]  rwa;

    rst = 1'b1; start = 1'b0; flush = 1'b0;
    op = 2'b00; dvd = '0; dvs = '0; waddr_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_waddr", 32'(waddr_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    vecs[0]  = '{2'b00, 32'h0000_0014, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFFA, 33};
    vecs[1]  = '{2'b10, 32'h0000_0014, 32'hFFFF_FFFD, 5'd2,  32'h0000_0002, 33};
    vecs[2]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 5'd7,  32'h7FFF_FFFF, 33};
    vecs[3]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 5'd7,  32'h0000_0001, 33};
    vecs[4]  = '{2'b01, 32'h0000_0007, 32'h0000_0000, 5'd3,  32'hFFFF_FFFF, 1};
    vecs[5]  = '{2'b11, 32'h0000_0007, 32'h0000_0000, 5'd4,  32'h0000_0007, 1};
    vecs[6]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5,  32'h8000_0000, 1};
    vecs[7]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 1};
    vecs[8]  = '{2'b01, 32'h0000_0003, 32'h0000_000A, 5'd8,  32'h0000_0000, EARLY_LAT};
    vecs[9]  = '{2'b11, 32'h0000_0003, 32'h0000_000A, 5'd9,  32'h0000_0003, EARLY_LAT};
    vecs[10] = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0002, 5'd30, 32'hFFFF_FFFD, 33};
    vecs[11] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 5'd31, 32'hFFFF_FFFF, 33};

    // Each vector starts in the IDLE cycle right after the previous DONE.
    for (int i = 0; i < 12; i++) begin
      op = vecs[i].op; dvd = vecs[i].a; dvs = vecs[i].b; waddr_in = vecs[i].wa;
      start = 1'b1;
      @(posedge clk);
      wait_result($sformatf("vec%0d", i), vecs[i].exp, vecs[i].lat, vecs[i].wa);
    end

    // Flush mid-CALC, then restart in the following cycle.
    op = 2'b00; dvd = 32'd100; dvs = 32'd7; waddr_in = 5'd3; start = 1'b1;
    @(posedge clk);
    nval = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (valid) nval++;
      if (k == 1) start = 1'b0;
      if (k == 10) flush = 1'b1;
    end
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_valid", 32'(valid), 32'd0);
    chk("flush_no_valid", 32'(nval), 32'd0);
    flush = 1'b0;
    op = 2'b01; dvd = 32'd1000; dvs = 32'd3; waddr_in = 5'd9; start = 1'b1;
    @(posedge clk);
    wait_result("after_flush", 32'd333, 33, 5'd9);

    // Flush together with start in IDLE: start is dropped.
    op = 2'b01; dvd = 32'd5; dvs = 32'd0; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("flush_start_busy", 32'(busy), 32'd0);
    chk("flush_start_valid", 32'(valid), 32'd0);
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy2", 32'(busy), 32'd0);

    // Reset in the middle of CALC discards the operation.
    op = 2'b01; dvd = 32'd50; dvs = 32'd5; waddr_in = 5'd11; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 5) rst = 1'b1;
    end
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_wen", 32'(wen), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_waddr", 32'(waddr_out), 32'd0);
    rst = 1'b0;
    nval = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid) nval++;
    end
    chk("midrst_no_valid", 32'(nval), 32'd0);

    // start_i toggled with junk operands while busy is ignored.
    op = 2'b00; dvd = 32'h0000_0014; dvs = 32'hFFFF_FFFD; waddr_in = 5'd12; start = 1'b1;
    @(posedge clk);
    nval = 0; lat = 0; res = '0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (valid) begin
        nval++;
        lat = k;
        res = result;
      end
      if (k < 30) begin
        start = (k % 2 == 0);
        dvd = $urandom;
        dvs = $urandom;
        op = 2'($urandom_range(0, 3));
      end else begin
        start = 1'b0;
      end
    end
    chk("toggle_count", 32'(nval), 32'd1);
    chk("toggle_lat", 32'(lat), 32'd33);
    chk("toggle_res", res, 32'hFFFF_FFFA);

    // Random operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      int sel;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      rwa = 5'($urandom_range(0, 31));
      sel = $urandom_range(0, 9);
      case (sel)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: begin ra = 32'($urandom_range(0, 100)); rb = 32'($urandom_range(1, 200)); end
        4: begin ra = 32'($urandom_range(0, 100)); rb = 32'hFFFF_FF00 | 32'($urandom_range(0, 255)); end
        default: ;
      endcase
      op = rop; dvd = ra; dvs = rb; waddr_in = rwa; start = 1'b1;
      @(posedge clk);
      wait_result($sformatf("rnd%0d_op%0d_%08h_%08h", i, rop, ra, rb),
                  ref_result(rop, ra, rb), ref_lat(rop, ra, rb), rwa);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_div_ctrl.md
Name: ex_div_ctrl

Overview:
- Multi-cycle sequencer for RV32M divide/remainder (DIV, DIVU, REM, REMU) beside the single-cycle execute ALU.
- Accepts one operation from the execute stage and runs a radix-2 restoring division, one quotient bit per cycle.
- Holds the pipeline via busy_o while running, then returns a one-cycle write-back result with its destination register.
- Aborts cleanly on pipeline flush (jump/branch taken).

Parameters:
DATA_WIDTH, 32, operand/result width in bits
CNT_WIDTH, $clog2(DATA_WIDTH), iteration counter width

Ports:
clk_i  input  1  clock; all state on rising edge
rst_i  input  1  synchronous, active-high reset
start_i  input  1  request; sampled only in IDLE
op_i  input  2  operation: DIV, DIVU, REM, REMU (package encoding)
dividend_i  input  DATA_WIDTH  rs1 value
divisor_i  input  DATA_WIDTH  rs2 value
reg_waddr_i  input  5  destination register
flush_i  input  1  abort current operation
busy_o  output  1  high whenever state != IDLE
valid_o  output  1  one-cycle result strobe
result_o  output  DATA_WIDTH  quotient or remainder
reg_wen_o  output  1  equals valid_o
reg_waddr_o  output  5  destination latched at start

Behaviour:
- Reset: state IDLE. busy_o, valid_o and reg_wen_o are 0. result_o and reg_waddr_o are 0. Counter and internal registers are 0. Reset mid-operation discards the operation; no valid_o is produced.
- States: IDLE, CALC, DONE.
- IDLE with start_i=1 and flush_i=0, in cycle N:
  - Latch op, |dividend|, |divisor|, quotient sign (dividend[31]^divisor[31]), remainder sign (dividend[31]) and reg_waddr_i.
  - Signed absolute values apply only to DIV and REM.
  - Special case divisor==0: quotient = all ones, remainder = dividend. Go to DONE.
  - Special case DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF: quotient = 0x80000000, remainder = 0. Go to DONE.
  - Otherwise clear the counter and go to CALC.
- CALC: one restoring step per cycle.
  - Shift {rem,quo} left by 1.
  - Trial = rem − divisor. If there is no borrow, rem = trial and quo[0] = 1.
  - After DATA_WIDTH steps (counter == DATA_WIDTH−1), go to DONE.
- DONE, held for exactly one cycle:
  - valid_o = reg_wen_o = 1.
  - result_o = quotient (DIV/DIVU) or remainder (REM/REMU).
  - Signed ops negate the quotient/remainder per their latched sign; special cases bypass negation.
  - Next state is IDLE.
- Latency from start in cycle N: normal ops give valid_o in cycle N+33; special cases give valid_o in cycle N+1.
- busy_o is high from N+1 through the DONE cycle inclusive.
- start_i outside IDLE is ignored. The execute stage must hold start_i while busy_o is high, or drop it.
- result_o and reg_waddr_o hold their last values after DONE until the next DONE.
- flush_i in any state: next state IDLE, valid_o and reg_wen_o = 0 next cycle. Flush in DONE suppresses that cycle's valid_o (valid_o = DONE & ~flush_i). flush_i and start_i together in IDLE: flush wins and the start is dropped.
- A back-to-back start in the cycle after DONE is accepted.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |dividend| < |divisor| (unsigned compare of absolute values, divisor != 0), go directly to DONE with quotient = 0 and remainder = the original dividend. valid_o arrives at N+1.
- Undefined: such operands take the full 32-step CALC path (identical result, valid_o at N+33).

Decomposition:
- Shared package ex_div_pkg:
  - op encoding enum: DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11
  - state enum: IDLE, CALC, DONE
  - constants DIV_ZERO_QUO = all ones, DIV_OVF_DIVIDEND = 0x80000000
- One natural sub-module: ex_div_step, a combinational single restoring step. Inputs are rem, quo and divisor; outputs are next rem and next quo. It is reusable for a future 2-bit-per-cycle variant.

Test Plan:
- DIV 20 / −3 (0x00000014, 0xFFFFFFFD) at cycle N -> valid_o at N+33, result_o 0xFFFFFFFA; REM same operands -> 0x00000002.
- DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF; REMU -> 0x00000001; reg_waddr_o equals reg_waddr_i latched at start (e.g. 5'd7), reg_wen_o high for exactly 1 cycle.
- DIVU 7 / 0 -> valid_o at N+1, result 0xFFFFFFFF; REMU 7 / 0 -> 7; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Start DIV at N, flush_i at N+10 -> busy_o low at N+11, no valid_o ever; new start at N+11 completes at N+44 with the correct result. Flush coincident with start in IDLE -> busy_o stays 0.
- rst_i asserted at N+5 mid-CALC -> all outputs 0 at N+6, no valid_o. start_i toggled while busy_o is high -> ignored, single result.
- DIVU 3 / 10 -> result 0. With DIV_EARLY_OUT_EN: valid at N+1. Without: valid at N+33. REMU -> 3 in both builds.
